// File: rtl/bra_pre_sel_ctrl.sv
// Chooser-table controller for a two-predictor branch selector.
// Sweeps the external table to INIT_VAL after reset, then serves 1-cycle
// lookups and read-modify-write counter updates over one shared table port.
// Ports:
//   clk, reset (async, active-low)
//   lkp_valid/lkp_addr/lkp_ready        lookup request
//   lkp_rsp_valid/lkp_rsp_sel           lookup response, one cycle after accept
//   upd_valid/upd_addr/upd_p1_ok/upd_p2_ok/upd_ready   update request
//   tab_wr_en/tab_addr/tab_wdata/tab_rdata             table port (comb read)
//   init_done                           init sweep finished
module bra_pre_sel_ctrl #(
    parameter int unsigned       ADDR_W     = 10,
    parameter int unsigned       DATA_W     = 2,
    parameter logic [DATA_W-1:0] INIT_VAL   = DATA_W'(1),
    parameter int unsigned       STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lkp_valid,
    input  logic [ADDR_W-1:0] lkp_addr,
    output logic              lkp_ready,
    output logic              lkp_rsp_valid,
    output logic              lkp_rsp_sel,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic              upd_p1_ok,
    input  logic              upd_p2_ok,
    output logic              upd_ready,
    output logic              tab_wr_en,
    output logic [ADDR_W-1:0] tab_addr,
    output logic [DATA_W-1:0] tab_wdata,
    input  logic [DATA_W-1:0] tab_rdata,
    output logic              init_done
);

    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);
    localparam logic [ADDR_W-1:0]   SWEEP_LAST = '1;
    localparam logic [DATA_W-1:0]   CNT_MAX    = '1;
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_UPD_RD,
        ST_UPD_WR
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   sweep_q, sweep_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [ADDR_W-1:0]   hold_addr_q, hold_addr_d;
    logic                hold_p1_q, hold_p1_d;
    logic                hold_p2_q, hold_p2_d;
    logic [DATA_W-1:0]   rd_val_q, rd_val_d;
    logic                lkp_rsp_valid_q, lkp_rsp_valid_d;
    logic                lkp_rsp_sel_q, lkp_rsp_sel_d;
    logic                init_done_q, init_done_d;

    logic                lkp_acc;
    logic                upd_acc;
    logic [DATA_W-1:0]   new_val;

    // Lookups win the shared port until the pending update has lost STARVE_MAX times.
    assign lkp_ready = (state_q == ST_IDLE) ||
                       ((state_q == ST_UPD_RD) && (starve_q != STARVE_LIM));
    assign lkp_acc   = lkp_valid && lkp_ready;
    assign upd_acc   = upd_valid && (state_q == ST_IDLE);

    // Saturating chooser-counter step toward whichever predictor alone was right.
    always_comb begin
        new_val = rd_val_q;
        if (hold_p2_q && !hold_p1_q && (rd_val_q != CNT_MAX)) begin
            new_val = rd_val_q + DATA_W'(1);
        end else if (hold_p1_q && !hold_p2_q && (rd_val_q != '0)) begin
            new_val = rd_val_q - DATA_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:   if (sweep_q == SWEEP_LAST) state_d = ST_IDLE;
            ST_IDLE:   if (upd_acc) state_d = ST_UPD_RD;
            ST_UPD_RD: if (!lkp_acc) state_d = ST_UPD_WR;
            ST_UPD_WR: state_d = ST_IDLE;
            default:   state_d = ST_INIT;
        endcase
    end

    // Table port and handshake outputs.
    always_comb begin
        upd_ready = 1'b0;
        tab_wr_en = 1'b0;
        tab_addr  = hold_addr_q;
        tab_wdata = new_val;
        case (state_q)
            ST_INIT: begin
                tab_wr_en = 1'b1;
                tab_addr  = sweep_q;
                tab_wdata = INIT_VAL;
            end
            ST_IDLE: begin
                upd_ready = 1'b1;
                if (lkp_acc) tab_addr = lkp_addr;
            end
            ST_UPD_RD: begin
                if (lkp_acc) tab_addr = lkp_addr;
            end
            ST_UPD_WR: begin
                // Skip the write when the counter did not move.
                tab_wr_en = (new_val != rd_val_q);
            end
            default: ;
        endcase
    end

    // Datapath next values.
    always_comb begin
        sweep_d         = sweep_q;
        starve_d        = starve_q;
        hold_addr_d     = hold_addr_q;
        hold_p1_d       = hold_p1_q;
        hold_p2_d       = hold_p2_q;
        rd_val_d        = rd_val_q;
        lkp_rsp_valid_d = 1'b0;
        lkp_rsp_sel_d   = lkp_rsp_sel_q;
        init_done_d     = init_done_q;

        if (lkp_acc) begin
            lkp_rsp_valid_d = 1'b1;
            lkp_rsp_sel_d   = tab_rdata[DATA_W-1];
        end

        case (state_q)
            ST_INIT: begin
                sweep_d = sweep_q + ADDR_W'(1);
                if (sweep_q == SWEEP_LAST) init_done_d = 1'b1;
            end
            ST_IDLE: begin
                if (upd_acc) begin
                    hold_addr_d = upd_addr;
                    hold_p1_d   = upd_p1_ok;
                    hold_p2_d   = upd_p2_ok;
                end
            end
            ST_UPD_RD: begin
                if (lkp_acc) begin
                    starve_d = starve_q + STARVE_W'(1);
                end else begin
                    rd_val_d = tab_rdata;
                    starve_d = '0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sweep_q         <= '0;
            starve_q        <= '0;
            hold_addr_q     <= '0;
            hold_p1_q       <= 1'b0;
            hold_p2_q       <= 1'b0;
            rd_val_q        <= '0;
            lkp_rsp_valid_q <= 1'b0;
            lkp_rsp_sel_q   <= 1'b0;
            init_done_q     <= 1'b0;
        end else begin
            sweep_q         <= sweep_d;
            starve_q        <= starve_d;
            hold_addr_q     <= hold_addr_d;
            hold_p1_q       <= hold_p1_d;
            hold_p2_q       <= hold_p2_d;
            rd_val_q        <= rd_val_d;
            lkp_rsp_valid_q <= lkp_rsp_valid_d;
            lkp_rsp_sel_q   <= lkp_rsp_sel_d;
            init_done_q     <= init_done_d;
        end
    end

    assign lkp_rsp_valid = lkp_rsp_valid_q;
    assign lkp_rsp_sel   = lkp_rsp_sel_q;
    assign init_done     = init_done_q;

endmodule
